pipe_stage_skid: RTL and testbench

- Parametrised pipeline boundary register, the successor to the fixed EX/MEM latch.
- Carries a control field and a data payload between two pipeline stages using a valid/ready handshake.
- Supports back-pressure (stall), synchronous flush and an optional 2-entry skid buffer that registers the ready path.
- Counts stall cycles for performance monitoring; instanced at every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_skid.sv | 70 +++++++
 tb/tb_pipe_stage_skid.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline boundary register with optional 2-entry skid buffer and stall counter
module pipe_stage_skid #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 5,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  // state encodes {main valid, skid valid}
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b10, HOLD = 2'b11} state_t;
  state_t state, state_nx;
  logic in_xfer, out_xfer, load_main, from_skid, load_skid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  assign in_xfer   = in_valid && in_ready && !flush;
  assign out_xfer  = out_valid && out_ready;
  assign from_skid = state == HOLD && out_xfer;
  assign load_main = in_xfer && (state == EMPTY || out_xfer);
  assign load_skid = state == FULL && in_xfer && !out_xfer;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = in_xfer ? FULL : EMPTY;
      FULL:    state_nx = (in_xfer && !out_xfer) ? HOLD : (out_xfer && !in_xfer) ? EMPTY : FULL;
      HOLD:    state_nx = out_xfer ? FULL : HOLD;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end
  // without a skid buffer, ready passes straight through from downstream
  always_comb begin
    out_valid = state[1];
    in_ready  = (SKID != 0) ? !state[0] : (!state[1] || out_ready);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
      stall_cnt <= '0;
    end else begin
      main_ctrl <= flush ? '0 : from_skid ? skid_ctrl : load_main ? in_ctrl : out_xfer ? '0 : main_ctrl;
      if (!flush && (from_skid || load_main)) main_data <= from_skid ? skid_data : in_data;
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of skid, pass-through and saturating-counter instances
module tb_pipe_stage_skid;
  logic clk = 0, reset = 1, flush = 0;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
  logic [4:0] a_in_ctrl = 0, a_out_ctrl;
  logic [68:0] a_in_data = 0, a_out_data;
  logic [15:0] a_stall;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
  logic [4:0] b_in_ctrl = 0, b_out_ctrl;
  logic [68:0] b_in_data = 0, b_out_data;
  logic [15:0] b_stall;
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
  logic [4:0] c_in_ctrl = 0, c_out_ctrl;
  logic [7:0] c_in_data = 0, c_out_data;
  logic [3:0] c_stall;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_stage_skid u_a (.clk(clk), .reset(reset), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall));
  pipe_stage_skid #(.SKID(0)) u_b (.clk(clk), .reset(reset), .flush(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall));
  pipe_stage_skid #(.DATA_W(8), .CNT_W(4)) u_c (.clk(clk), .reset(reset), .flush(1'b0), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .in_ctrl(c_in_ctrl), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data), .stall_cnt(c_stall));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_ctrl", a_out_ctrl, 0);
    chk("rst_data", a_out_data, 0);
    chk("rst_stall", a_stall, 0);
    reset = 0;
    a_in_valid = 1; a_in_ctrl = 5'h3;
    for (int i = 1; i <= 4; i++) begin
      a_in_data = 69'(i);
      step();
      chk("stream_data", a_out_data, 128'(i));
      chk("stream_valid", a_out_valid, 1);
    end
    a_in_valid = 0;
    chk("stream_ctrl", a_out_ctrl, 5'h3);
    step();
    chk("drain_valid", a_out_valid, 0);
    chk("drain_ctrl0", a_out_ctrl, 0);
    chk("stream_stall", a_stall, 0);
    a_in_valid = 1; a_in_ctrl = 5'h1; a_in_data = 69'hA;
    step();
    chk("bp_a", a_out_data, 'hA);
    a_out_ready = 0; a_in_data = 69'hB;
    step();
    chk("bp_ready_low", a_in_ready, 0);
    a_in_data = 69'hC;
    step();
    step();
    chk("bp_hold_a", a_out_data, 'hA);
    chk("bp_hold_ctrl", a_out_ctrl, 5'h1);
    a_out_ready = 1;
    step();
    chk("bp_b", a_out_data, 'hB);
    chk("bp_ready_high", a_in_ready, 1);
    step();
    a_in_valid = 0;
    chk("bp_c", a_out_data, 'hC);
    step();
    chk("bp_empty", a_out_valid, 0);
    chk("bp_stall", a_stall, 3);
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 5'h2; a_in_data = 69'h11;
    step();
    a_in_data = 69'h12;
    step();
    chk("fl_skid_full", a_in_ready, 0);
    flush = 1; a_in_ctrl = 5'h1F; a_in_data = 69'h13;
    step();
    flush = 0; a_in_valid = 0; a_out_ready = 1;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ctrl", a_out_ctrl, 0);
    chk("fl_ready", a_in_ready, 1);
    chk("fl_stall", a_stall, 5);
    step();
    chk("fl_gone", a_out_valid, 0);
    a_in_valid = 1; a_in_ctrl = 5'h4; a_in_data = 69'h14;
    step();
    chk("fl_after_data", a_out_data, 'h14);
    chk("fl_after_ctrl", a_out_ctrl, 5'h4);
    a_out_ready = 0; a_in_data = 69'h21;
    step();
    a_in_data = 69'h22;
    step();
    a_in_valid = 0;
    #3 reset = 1;
    #1;
    chk("ar_valid", a_out_valid, 0);
    chk("ar_ctrl", a_out_ctrl, 0);
    chk("ar_data", a_out_data, 0);
    chk("ar_stall", a_stall, 0);
    chk("ar_ready", a_in_ready, 1);
    #2 reset = 0;
    a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 5'h2; a_in_data = 69'h33;
    step();
    a_in_valid = 0;
    chk("ar_lat_data", a_out_data, 'h33);
    chk("ar_lat_valid", a_out_valid, 1);
    step();
    chk("ar_lat_empty", a_out_valid, 0);
    chk("s0_ready_empty", b_in_ready, 1);
    b_in_valid = 1; b_in_ctrl = 5'h6; b_in_data = 69'h5; b_out_ready = 0;
    step();
    chk("s0_load", b_out_data, 'h5);
    chk("s0_ready_low", b_in_ready, 0);
    b_in_data = 69'h6;
    step();
    chk("s0_hold", b_out_data, 'h5);
    b_out_ready = 1;
    #1;
    chk("s0_ready_comb", b_in_ready, 1);
    step();
    b_in_valid = 0;
    chk("s0_next", b_out_data, 'h6);
    step();
    chk("s0_empty", b_out_valid, 0);
    chk("s0_ctrl0", b_out_ctrl, 0);
    chk("s0_stall", b_stall, 1);
    c_in_valid = 1; c_in_data = 8'h9; c_out_ready = 0;
    step();
    c_in_valid = 0;
    repeat (14) step();
    chk("sat_14", c_stall, 14);
    repeat (6) step();
    chk("sat_15", c_stall, 15);
    chk("sat_data", c_out_data, 8'h9);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
